// File: rtl/sub8_digit_serial.sv
// sub8_digit_serial: 8-bit subtractor, two bits per clock.
// Optional LT/LTU compare flags under SUB8_CMP_EN.
module sub8_digit_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] Xi,
  input  logic [7:0] Yi,
  input  logic       B0,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] Di,
  output logic       B8,
  output logic       V,
  output logic       Z
`ifdef SUB8_CMP_EN
  ,
  output logic       LT,
  output logic       LTU
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  xr_q, xr_d;
  logic [7:0]  yr_q, yr_d;
  logic [7:0]  dr_q, dr_d;
  logic        c_q, c_d;
  logic        load;

  logic [7:0]  di_q;
  logic        b8_q, v_q, z_q;

  logic [1:0]  a, b;
  logic        s0, s1, c1, c2;

  // Slice operands and two chained full adders
  always_comb begin
    a  = xr_q[{k_q, 1'b0} +: 2];
    b  = yr_q[{k_q, 1'b0} +: 2];
    s0 = a[0] ^ b[0] ^ c_q;
    c1 = (a[0] & b[0]) | (a[0] & c_q) | (b[0] & c_q);
    s1 = a[1] ^ b[1] ^ c1;
    c2 = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    dr_d    = dr_q;
    c_d     = c_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          xr_d    = Xi;
          yr_d    = ~Yi;
          c_d     = ~B0;
          k_d     = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        dr_d = {s1, s0, dr_q[7:2]};
        c_d  = c2;
        k_d  = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DONE;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      xr_q    <= 8'h00;
      yr_q    <= 8'h00;
      dr_q    <= 8'h00;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      dr_q    <= dr_d;
      c_q     <= c_d;
    end
  end

  // Result registers load on the final RUN cycle only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      di_q <= 8'h00;
      b8_q <= 1'b0;
      v_q  <= 1'b0;
      z_q  <= 1'b0;
    end else if (load) begin
      di_q <= dr_d;
      b8_q <= ~c2;
      v_q  <= c1 ^ c2;
      z_q  <= (dr_d == 8'h00);
    end
  end

`ifdef SUB8_CMP_EN
  logic lt_q, ltu_q;

  // Compare flags share the result load edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_q  <= 1'b0;
      ltu_q <= 1'b0;
    end else if (load) begin
      lt_q  <= dr_d[7] ^ (c1 ^ c2);
      ltu_q <= ~c2;
    end
  end

  assign LT  = lt_q;
  assign LTU = ltu_q;
`endif

  assign busy  = (state_q == RUN);
  assign ready = ~busy;
  assign done  = (state_q == DONE);
  assign Di    = di_q;
  assign B8    = b8_q;
  assign V     = v_q;
  assign Z     = z_q;

endmodule

// File: tb/tb_sub8_digit_serial.sv
// Scoreboard bench for sub8_digit_serial.
// Reference model uses plain integer subtraction.
module tb_sub8_digit_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] Xi = 8'h00;
  logic [7:0] Yi = 8'h00;
  logic       B0 = 1'b0;
  logic       ready, busy, done;
  logic [7:0] Di;
  logic       B8, V, Z;
`ifdef SUB8_CMP_EN
  logic       LT, LTU;
`endif

  sub8_digit_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Xi    (Xi),
    .Yi    (Yi),
    .B0    (B0),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .Di    (Di),
    .B8    (B8),
    .V     (V),
    .Z     (Z)
`ifdef SUB8_CMP_EN
    ,
    .LT    (LT),
    .LTU   (LTU)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       b, v, z, lt, ltu;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  logic held   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic bi, input int acc);
    exp_t e;
    int   ud, sd;
    ud    = int'(x) - int'(y) - int'(bi);
    sd    = int'($signed(x)) - int'($signed(y)) - int'(bi);
    e.d   = 8'(ud);
    e.b   = (ud < 0);
    e.v   = (sd < -128) || (sd > 127);
    e.z   = (e.d == 8'h00);
    e.lt  = (sd < 0);
    e.ltu = (ud < 0);
    e.acc = acc;
    return e;
  endfunction

  // Drive one cycle from a negedge; record an accepted request
  task automatic drive(input logic s, input logic [7:0] x,
                       input logic [7:0] y, input logic bi);
    start = s;
    Xi    = x;
    Yi    = y;
    B0    = bi;
    if (s && ready) q.push_back(model(x, y, bi, cyc + 1));
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_Di"}, Di, 0);
    chk({tag, "_B8V Z"}, {B8, V, Z}, 0);
`ifdef SUB8_CMP_EN
    chk({tag, "_LT"}, {LT, LTU}, 0);
`endif
  endtask

  // Monitor: pops the scoreboard on every done pulse
  initial begin
    exp_t       e;
    logic [7:0] hold_d    = 8'h00;
    int         busy_n    = 0;
    int         last_done = -1;
    logic       held_p    = 1'b0;
    forever begin
      @(negedge clk);
      if (held && !held_p) last_done = -1;
      held_p = held;
      if (rst) begin
        hold_d = 8'h00;
        busy_n = 0;
      end else begin
        if (busy) begin
          busy_n++;
          chk("Di_stable_in_run", Di, hold_d);
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("Di", Di, e.d);
            chk("B8", B8, e.b);
            chk("V", V, e.v);
            chk("Z", Z, e.z);
`ifdef SUB8_CMP_EN
            chk("LT", LT, e.lt);
            chk("LTU", LTU, e.ltu);
`endif
            chk("latency", cyc - e.acc, 4);
            chk("busy_cycles", busy_n, 4);
            if (held && last_done >= 0) chk("held_spacing", cyc - last_done, 5);
            last_done = cyc;
            hold_d    = e.d;
          end
          busy_n = 0;
        end
      end
    end
  end

  initial begin
    logic [7:0] px0, py0, px1, py1;
    logic       pb0, pb1;
    repeat (2) @(negedge clk);
    chk_reset_state("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("post_rst");

    // Directed vectors
    wait_ready(); drive(1'b1, 8'h5A, 8'h3C, 1'b0); drain();
    wait_ready(); drive(1'b1, 8'h10, 8'h20, 1'b0); drain();
    wait_ready(); drive(1'b1, 8'h80, 8'h01, 1'b0); drain();
    wait_ready(); drive(1'b1, 8'h37, 8'h36, 1'b1); drain();
    wait_ready(); drive(1'b1, 8'h00, 8'hFF, 1'b1); drain();
    wait_ready(); drive(1'b1, 8'h7F, 8'h80, 1'b0); drain();

    // Start during RUN is ignored
    wait_ready();
    drive(1'b1, 8'h5A, 8'h3C, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'hC3, 8'h11, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drain();

    // Reset in the second RUN cycle aborts with no done
    wait_ready();
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    q.delete();
    #1;
    chk_reset_state("mid_run_rst");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    repeat (8) drive(1'b0, 8'h00, 8'h00, 1'b0);

    // Start held high with alternating operand pairs
    wait_ready();
    px0 = 8'($urandom); py0 = 8'($urandom); pb0 = 1'($urandom);
    px1 = 8'($urandom); py1 = 8'($urandom); pb1 = 1'($urandom);
    held = 1'b1;
    for (int i = 0; i < 42; i++) begin
      if (i % 2 == 0) drive(1'b1, px0, py0, pb0);
      else drive(1'b1, px1, py1, pb1);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drain();
    held = 1'b0;

    // Random traffic, including starts while busy
    for (int i = 0; i < 500; i++)
      drive(($urandom % 3) == 0, 8'($urandom), 8'($urandom), 1'($urandom));
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
